mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit: issues loads/stores on a split-transaction sram-like bus,
// tracks in-flight accesses in order, and aligns/merges load data on return.

module mem_access_unit_chk (
    input logic clk,
    input logic resetn,
    input logic data_ok,
    input logic cnt_nz
);
    // A response with nothing outstanding means the bus agent broke protocol.
    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn) (data_ok |-> cnt_nz))
        else $error("data_data_ok with empty pending queue");
endmodule

module mem_access_unit #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int TAG_W           = 4,
    parameter int UNALIGNED_EN    = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_load_op,
    input  logic [4:0]       in_store_op,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_wdata,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             ex_valid,
    output logic [4:0]       ex_code,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [3:0]       data_wstrb,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [31:0]      data_rdata,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;

    logic [6:0]       r_q_load_op [MAX_OUTSTANDING];
    logic [1:0]       r_q_off     [MAX_OUTSTANDING];
    logic [31:0]      r_q_rt      [MAX_OUTSTANDING];
    logic [TAG_W-1:0] r_q_tag     [MAX_OUTSTANDING];
    logic             r_q_disc    [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic       w_adel;
    logic       w_ades;
    logic       w_ri;
    logic       w_space;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_off;

    function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Store entries carry load_op == 0 and therefore return zero.
    function automatic logic [31:0] f_load_result(input logic [6:0]  op,
                                                  input logic [1:0]  off,
                                                  input logic [31:0] rt,
                                                  input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = rd[{off, 3'b000} +: 8];
        h   = off[1] ? rd[31:16] : rd[15:0];
        res = 32'h0000_0000;
        if (op[0]) begin
            res = {{24{b[7]}}, b};
        end else if (op[1]) begin
            res = {24'h00_0000, b};
        end else if (op[2]) begin
            res = {{16{h[15]}}, h};
        end else if (op[3]) begin
            res = {16'h0000, h};
        end else if (op[4]) begin
            res = rd;
        end else if (op[5]) begin
            case (off)
                2'd0:    res = {rd[7:0],  rt[23:0]};
                2'd1:    res = {rd[15:0], rt[15:0]};
                2'd2:    res = {rd[23:0], rt[7:0]};
                default: res = rd;
            endcase
        end else if (op[6]) begin
            case (off)
                2'd0:    res = rd;
                2'd1:    res = {rt[31:24], rd[31:8]};
                2'd2:    res = {rt[31:16], rd[31:16]};
                default: res = {rt[31:8],  rd[31:24]};
            endcase
        end else begin
            res = 32'h0000_0000;
        end
        return res;
    endfunction

    assign w_off = in_addr[1:0];

    // Issue-time fault decode.
    always_comb begin
        w_adel = in_valid & (((in_load_op[2] | in_load_op[3]) & in_addr[0]) |
                             (in_load_op[4] & (in_addr[1:0] != 2'b00)));
        w_ades = in_valid & ((in_store_op[1] & in_addr[0]) |
                             (in_store_op[2] & (in_addr[1:0] != 2'b00)));
        if (UNALIGNED_EN == 0) begin
            w_ri = in_valid & (in_load_op[5] | in_load_op[6] | in_store_op[3] | in_store_op[4]);
        end else begin
            w_ri = 1'b0;
        end
        ex_valid = w_adel | w_ades | w_ri;
        if (w_ri) begin
            ex_code = EXCCODE_RI;
        end else if (w_adel) begin
            ex_code = EXCCODE_ADEL;
        end else if (w_ades) begin
            ex_code = EXCCODE_ADES;
        end else begin
            ex_code = 5'd0;
        end
    end

    assign w_space  = (r_count < CNT_W'(MAX_OUTSTANDING));
    assign data_req = in_valid & ~ex_valid & ~flush & w_space;
    assign in_ready = w_space & (~data_req | data_addr_ok);
    assign w_push   = data_req & data_addr_ok;
    assign w_pop    = data_data_ok & (r_count != CNT_W'(0));

    // Bus request fields: size, strobes, lane-placed write data and address.
    always_comb begin
        data_wr    = |in_store_op;
        data_size  = 2'd2;
        data_wstrb = 4'h0;
        data_addr  = in_addr;
        data_wdata = 32'h0000_0000;
        if (|in_store_op) begin
            if (in_store_op[0]) begin
                data_size  = 2'd0;
                data_wstrb = 4'b0001 << w_off;
                data_wdata = {4{in_wdata[7:0]}};
            end else if (in_store_op[1]) begin
                data_size  = 2'd1;
                data_wstrb = w_off[1] ? 4'hC : 4'h3;
                data_wdata = {2{in_wdata[15:0]}};
            end else if (in_store_op[2]) begin
                data_wstrb = 4'hF;
                data_wdata = in_wdata;
            end else if (in_store_op[3]) begin
                data_addr = {in_addr[31:2], 2'b00};
                case (w_off)
                    2'd0:    begin data_wstrb = 4'h1; data_wdata = in_wdata >> 24; end
                    2'd1:    begin data_wstrb = 4'h3; data_wdata = in_wdata >> 16; end
                    2'd2:    begin data_wstrb = 4'h7; data_wdata = in_wdata >> 8;  end
                    default: begin data_wstrb = 4'hF; data_wdata = in_wdata;       end
                endcase
            end else begin
                data_addr = {in_addr[31:2], 2'b00};
                case (w_off)
                    2'd0:    begin data_wstrb = 4'hF; data_wdata = in_wdata;       end
                    2'd1:    begin data_wstrb = 4'hE; data_wdata = in_wdata << 8;  end
                    2'd2:    begin data_wstrb = 4'hC; data_wdata = in_wdata << 16; end
                    default: begin data_wstrb = 4'h8; data_wdata = in_wdata << 24; end
                endcase
            end
        end else begin
            if (in_load_op[0] | in_load_op[1]) begin
                data_size = 2'd0;
            end else if (in_load_op[2] | in_load_op[3]) begin
                data_size = 2'd1;
            end else begin
                data_size = 2'd2;
            end
            if (in_load_op[5] | in_load_op[6]) begin
                data_addr = {in_addr[31:2], 2'b00};
            end else begin
                data_addr = in_addr;
            end
        end
    end

    // Pending queue, occupancy and registered response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_q_load_op[i] <= 7'd0;
                r_q_off[i]     <= 2'd0;
                r_q_rt[i]      <= 32'h0000_0000;
                r_q_tag[i]     <= '0;
                r_q_disc[i]    <= 1'b0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0000_0000;
            resp_tag   <= '0;
        end else begin
            if (w_push) begin
                r_q_load_op[r_wr_ptr] <= in_load_op;
                r_q_off[r_wr_ptr]     <= w_off;
                r_q_rt[r_wr_ptr]      <= in_wdata;
                r_q_tag[r_wr_ptr]     <= in_tag;
                r_q_disc[r_wr_ptr]    <= 1'b0;
                r_wr_ptr              <= f_ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_next(r_rd_ptr);
            end
            if (flush) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    r_q_disc[i] <= 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            resp_valid <= w_pop & ~r_q_disc[r_rd_ptr] & ~flush;
            if (w_pop) begin
                resp_data <= f_load_result(r_q_load_op[r_rd_ptr], r_q_off[r_rd_ptr],
                                           r_q_rt[r_rd_ptr], data_rdata);
                resp_tag  <= r_q_tag[r_rd_ptr];
            end else begin
                resp_data <= resp_data;
                resp_tag  <= resp_tag;
            end
        end
    end

    mem_access_unit_chk u_chk (
        .clk     (clk),
        .resetn  (resetn),
        .data_ok (data_data_ok),
        .cnt_nz  (r_count != CNT_W'(0))
    );
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default build (depth 2) plus a depth-1 build.

module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        resetn_a, resetn_b;
    logic        in_valid, flush;
    logic [6:0]  in_load_op;
    logic [4:0]  in_store_op;
    logic [31:0] in_addr, in_wdata, data_rdata;
    logic [3:0]  in_tag;
    logic        data_addr_ok, data_data_ok;

    logic        in_ready_a, ex_valid_a, data_req_a, data_wr_a, resp_valid_a;
    logic [4:0]  ex_code_a;
    logic [1:0]  data_size_a;
    logic [3:0]  data_wstrb_a, resp_tag_a;
    logic [31:0] data_addr_a, data_wdata_a, resp_data_a;

    logic        in_ready_b, ex_valid_b, data_req_b, data_wr_b, resp_valid_b;
    logic [4:0]  ex_code_b;
    logic [1:0]  data_size_b;
    logic [3:0]  data_wstrb_b, resp_tag_b;
    logic [31:0] data_addr_b, data_wdata_b, resp_data_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MAX_OUTSTANDING(2), .TAG_W(4), .UNALIGNED_EN(1)) dut_a (
        .clk(clk), .resetn(resetn_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_load_op(in_load_op), .in_store_op(in_store_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_tag(in_tag), .flush(flush),
        .ex_valid(ex_valid_a), .ex_code(ex_code_a),
        .data_req(data_req_a), .data_wr(data_wr_a), .data_size(data_size_a),
        .data_wstrb(data_wstrb_a), .data_addr(data_addr_a), .data_wdata(data_wdata_a),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(resp_valid_a), .resp_data(resp_data_a), .resp_tag(resp_tag_a)
    );

    mem_access_unit #(.MAX_OUTSTANDING(1), .TAG_W(4), .UNALIGNED_EN(1)) dut_b (
        .clk(clk), .resetn(resetn_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_load_op(in_load_op), .in_store_op(in_store_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_tag(in_tag), .flush(flush),
        .ex_valid(ex_valid_b), .ex_code(ex_code_b),
        .data_req(data_req_b), .data_wr(data_wr_b), .data_size(data_size_b),
        .data_wstrb(data_wstrb_b), .data_addr(data_addr_b), .data_wdata(data_wdata_b),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_tag(resp_tag_b)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic [6:0] lop, input logic [4:0] sop,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] tag);
        in_valid    = 1'b1;
        in_load_op  = lop;
        in_store_op = sop;
        in_addr     = addr;
        in_wdata    = wd;
        in_tag      = tag;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_load_op  = 7'd0;
        in_store_op = 5'd0;
    endtask

    task automatic do_store(input string name, input logic [4:0] sop, input logic [31:0] addr,
                            input logic [31:0] rt, input logic [3:0] tag,
                            input logic [3:0] e_strb, input logic [31:0] e_wdata,
                            input logic [31:0] e_addr, input logic [1:0] e_size);
        drive(7'd0, sop, addr, rt, tag);
        data_addr_ok = 1'b1;
        settle();
        check({name, "_req"},   {31'd0, data_req_a}, 32'd1);
        check({name, "_wr"},    {31'd0, data_wr_a},  32'd1);
        check({name, "_strb"},  {28'd0, data_wstrb_a}, {28'd0, e_strb});
        check({name, "_wdata"}, data_wdata_a, e_wdata);
        check({name, "_addr"},  data_addr_a, e_addr);
        check({name, "_size"},  {30'd0, data_size_a}, {30'd0, e_size});
        step();
        idle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        settle();
        check({name, "_rvalid"}, {31'd0, resp_valid_a}, 32'd1);
        check({name, "_rdata"},  resp_data_a, 32'h0);
        check({name, "_rtag"},   {28'd0, resp_tag_a}, {28'd0, tag});
        step();
    endtask

    task automatic do_load(input string name, input logic [6:0] lop, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [3:0] tag,
                           input logic [31:0] e_addr, input logic [1:0] e_size,
                           input logic [31:0] rdata, input logic [31:0] e_res);
        drive(lop, 5'd0, addr, rt, tag);
        data_addr_ok = 1'b1;
        settle();
        check({name, "_req"},  {31'd0, data_req_a}, 32'd1);
        check({name, "_strb"}, {28'd0, data_wstrb_a}, 32'd0);
        check({name, "_addr"}, data_addr_a, e_addr);
        check({name, "_size"}, {30'd0, data_size_a}, {30'd0, e_size});
        step();
        idle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        step();
        data_data_ok = 1'b0;
        settle();
        check({name, "_rvalid"}, {31'd0, resp_valid_a}, 32'd1);
        check({name, "_rdata"},  resp_data_a, e_res);
        check({name, "_rtag"},   {28'd0, resp_tag_a}, {28'd0, tag});
        step();
    endtask

    initial begin
        resetn_a = 1'b0; resetn_b = 1'b0;
        idle();
        in_addr = 32'h0; in_wdata = 32'h0; in_tag = 4'd0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        check("rst_req",    {31'd0, data_req_a},   32'd0);
        check("rst_rvalid", {31'd0, resp_valid_a}, 32'd0);
        check("rst_ex",     {31'd0, ex_valid_a},   32'd0);
        check("rst_rdata",  resp_data_a, 32'h0);
        check("rst_rtag",   {28'd0, resp_tag_a}, 32'd0);
        check("rst_ready",  {31'd0, in_ready_a}, 32'd1);
        step(); step();
        resetn_a = 1'b1;
        step();

        do_store("sb", 5'b00001, 32'h0000_1003, 32'h0000_00AB, 4'd3, 4'h8, 32'hABAB_ABAB, 32'h0000_1003, 2'd0);
        do_store("sh", 5'b00010, 32'h0000_0012, 32'h0000_BEEF, 4'd4, 4'hC, 32'hBEEF_BEEF, 32'h0000_0012, 2'd1);
        do_store("swl", 5'b01000, 32'h0000_0101, 32'h1122_3344, 4'd5, 4'h3, 32'h0000_1122, 32'h0000_0100, 2'd2);
        do_store("swr", 5'b10000, 32'h0000_0102, 32'h1122_3344, 4'd6, 4'hC, 32'h3344_0000, 32'h0000_0100, 2'd2);

        // Faulting requests: no bus activity, queue untouched.
        drive(7'b0010000, 5'd0, 32'h0000_2002, 32'h0, 4'd1);
        settle();
        check("adel_ex",   {31'd0, ex_valid_a}, 32'd1);
        check("adel_code", {27'd0, ex_code_a},  32'd4);
        check("adel_req",  {31'd0, data_req_a}, 32'd0);
        check("adel_rdy",  {31'd0, in_ready_a}, 32'd1);
        step();
        check("adel_cnt",  {30'd0, dut_a.r_count}, 32'd0);
        drive(7'd0, 5'b00010, 32'h0000_2001, 32'h0, 4'd1);
        settle();
        check("ades_ex",   {31'd0, ex_valid_a}, 32'd1);
        check("ades_code", {27'd0, ex_code_a},  32'd5);
        check("ades_req",  {31'd0, data_req_a}, 32'd0);
        step();
        idle();

        // Two back-to-back byte loads fill the queue.
        data_addr_ok = 1'b1;
        drive(7'b0000001, 5'd0, 32'h0000_0010, 32'h0, 4'd1);
        settle();
        check("lb0_req", {31'd0, data_req_a}, 32'd1);
        step();
        drive(7'b0000001, 5'd0, 32'h0000_0013, 32'h0, 4'd2);
        settle();
        check("lb1_req", {31'd0, data_req_a}, 32'd1);
        step();
        drive(7'b0000001, 5'd0, 32'h0000_0020, 32'h0, 4'd5);
        settle();
        check("full_rdy", {31'd0, in_ready_a}, 32'd0);
        check("full_req", {31'd0, data_req_a}, 32'd0);
        check("full_cnt", {30'd0, dut_a.r_count}, 32'd2);
        idle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h80FF_1280;
        step();
        settle();
        check("lb0_rvalid", {31'd0, resp_valid_a}, 32'd1);
        check("lb0_rdata",  resp_data_a, 32'hFFFF_FF80);
        check("lb0_rtag",   {28'd0, resp_tag_a}, 32'd1);
        step();
        data_data_ok = 1'b0;
        settle();
        check("lb1_rvalid", {31'd0, resp_valid_a}, 32'd1);
        check("lb1_rdata",  resp_data_a, 32'hFFFF_FF80);
        check("lb1_rtag",   {28'd0, resp_tag_a}, 32'd2);
        step();

        do_load("lbu", 7'b0000010, 32'h0000_0011, 32'h0, 4'd3, 32'h0000_0011, 2'd0, 32'h80FF_1280, 32'h0000_0012);
        do_load("lh",  7'b0000100, 32'h0000_0012, 32'h0, 4'd4, 32'h0000_0012, 2'd1, 32'h80FF_1280, 32'hFFFF_80FF);
        do_load("lhu", 7'b0001000, 32'h0000_0012, 32'h0, 4'd5, 32'h0000_0012, 2'd1, 32'h80FF_1280, 32'h0000_80FF);
        do_load("lwl", 7'b0100000, 32'h0000_0101, 32'h1122_3344, 4'd6, 32'h0000_0100, 2'd2, 32'hAABB_CCDD, 32'hCCDD_3344);
        do_load("lwr", 7'b1000000, 32'h0000_0102, 32'h1122_3344, 4'd7, 32'h0000_0100, 2'd2, 32'hAABB_CCDD, 32'h1122_AABB);

        // Simultaneous push and pop keeps the count.
        data_addr_ok = 1'b1;
        drive(7'b0010000, 5'd0, 32'h0000_0050, 32'h0, 4'd9);
        step();
        drive(7'b0010000, 5'd0, 32'h0000_0054, 32'h0, 4'd10);
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111_1111;
        settle();
        check("pp_rdy", {31'd0, in_ready_a}, 32'd1);
        check("pp_req", {31'd0, data_req_a}, 32'd1);
        step();
        idle();
        data_addr_ok = 1'b0;
        data_rdata   = 32'h2222_2222;
        settle();
        check("pp_cnt",   {30'd0, dut_a.r_count}, 32'd1);
        check("pp0_tag",  {28'd0, resp_tag_a}, 32'd9);
        check("pp0_data", resp_data_a, 32'h1111_1111);
        step();
        data_data_ok = 1'b0;
        settle();
        check("pp1_tag",  {28'd0, resp_tag_a}, 32'd10);
        check("pp1_data", resp_data_a, 32'h2222_2222);
        check("pp1_cnt",  {30'd0, dut_a.r_count}, 32'd0);
        step();

        // Flush with two loads in flight.
        data_addr_ok = 1'b1;
        drive(7'b0010000, 5'd0, 32'h0000_0040, 32'h0, 4'd6);
        step();
        drive(7'b0010000, 5'd0, 32'h0000_0044, 32'h0, 4'd7);
        step();
        idle();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_5555;
        step();
        settle();
        check("fl_pop0", {31'd0, resp_valid_a}, 32'd0);
        step();
        data_data_ok = 1'b0;
        settle();
        check("fl_pop1", {31'd0, resp_valid_a}, 32'd0);
        check("fl_cnt",  {30'd0, dut_a.r_count}, 32'd0);
        step();
        do_load("postfl", 7'b0010000, 32'h0000_0048, 32'h0, 4'd8, 32'h0000_0048, 2'd2, 32'h1234_5678, 32'h1234_5678);

        // Depth-1 build: no push while full, then reset mid-flight.
        resetn_a = 1'b0;
        resetn_b = 1'b1;
        step();
        data_addr_ok = 1'b1;
        drive(7'b0010000, 5'd0, 32'h0000_0060, 32'h0, 4'd1);
        settle();
        check("b_req0", {31'd0, data_req_b}, 32'd1);
        step();
        drive(7'b0010000, 5'd0, 32'h0000_0064, 32'h0, 4'd2);
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_F00D;
        settle();
        check("b_full_req", {31'd0, data_req_b}, 32'd0);
        check("b_full_rdy", {31'd0, in_ready_b}, 32'd0);
        step();
        data_data_ok = 1'b0;
        settle();
        check("b_rvalid", {31'd0, resp_valid_b}, 32'd1);
        check("b_rtag",   {28'd0, resp_tag_b}, 32'd1);
        check("b_rdata",  resp_data_b, 32'hCAFE_F00D);
        check("b_cnt0",   {31'd0, dut_b.r_count}, 32'd0);
        check("b_req1",   {31'd0, data_req_b}, 32'd1);
        step();
        idle();
        data_addr_ok = 1'b0;
        settle();
        check("b_cnt1", {31'd0, dut_b.r_count}, 32'd1);
        resetn_b = 1'b0;
        #1;
        check("b_rst_cnt",   {31'd0, dut_b.r_count}, 32'd0);
        check("b_rst_rdata", resp_data_b, 32'h0);
        check("b_rst_rtag",  {28'd0, resp_tag_b}, 32'd0);
        check("b_rst_rv",    {31'd0, resp_valid_b}, 32'd0);
        check("b_rst_rdy",   {31'd0, in_ready_b}, 32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
